// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and sizing helpers for the register file /
// load scoreboard block.
//   REG_ZERO    - architectural register hard-wired to zero
//   addr_width  - register address width for a given register count
//   cnt_width   - scoreboard counter width able to hold 0..max_out
package rf_pkg;

  localparam int REG_ZERO = 0;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  function automatic int cnt_width(input int max_out);
    return (max_out > 0) ? $clog2(max_out + 1) : 1;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// sb_counter: one saturating up/down counter with synchronous clear, used to
// track outstanding loads for a single destination register.
// Ports:
//   sys_clk, rst_n - clock, asynchronous active-low reset
//   clr_i          - clear to zero at next edge (wins over everything)
//   en_i           - update enable (low while the pipeline is stalled)
//   inc_i, dec_i   - count up / down; both together leave the count alone
//   cnt_o          - current count
//   nz_o           - count is non-zero
module sb_counter
  import rf_pkg::*;
#(
  parameter int MAX_OUT = 3,
  parameter int CW      = cnt_width(MAX_OUT)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          nz_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear first, then saturating inc or floor-clamped dec.
  // A clear is honoured even while stalled so a squash is never lost.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (en_i && dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: ID-stage register file with write-back bypass and a
// per-register scoreboard of outstanding loads.
// Ports:
//   sys_clk, rst_n                 - clock, asynchronous active-low reset
//   stall_i                        - blocks register writes and scoreboard updates
//   flush_i                        - clears the scoreboard, masks the bubble
//   rd_en_i / rd_addr_i / rd_data_o - NRD combinational read ports (packed)
//   wb_en_i / wb_addr_i / wb_data_i / wb_is_load_i - write-back port
//   issue_en_i / issue_dst_i / issue_is_load_i     - instruction leaving ID
//   insert_bubble_o                - hold IF/ID and inject a NOP
//   busy_o                         - per-register "loads outstanding" flags
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int MAX_OUT = 3,
  parameter int AW      = addr_width(NREGS)
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic                wb_en_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                wb_is_load_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_dst_i,
  input  logic                issue_is_load_i,
  output logic                insert_bubble_o,
  output logic [NREGS-1:0]    busy_o
);

  localparam int            CW      = cnt_width(MAX_OUT);
  localparam logic [AW-1:0] ADDR_R0 = AW'(REG_ZERO);

  logic [XLEN-1:0]             regs_q [NREGS];
  logic [NREGS-1:0][CW-1:0]    cnt_s;
  logic [NREGS-1:0]            nz_s;
  logic                        wb_fire_s;
  logic                        wb_load_fire_s;
  logic                        hazard_s;
  logic                        full_s;
  logic                        bubble_s;

  assign wb_fire_s      = wb_en_i && !stall_i && (wb_addr_i != ADDR_R0);
  assign wb_load_fire_s = wb_en_i && wb_is_load_i && !stall_i;

  // Register 0 has no counter.
  assign cnt_s[0] = '0;
  assign nz_s[0]  = 1'b0;

  // One counter per real register. A load held back by the bubble is not
  // counted, since it stays in ID and re-issues later.
  for (genvar r = 1; r < NREGS; r++) begin : g_sb
    logic inc_s;
    logic dec_s;
    assign inc_s = issue_en_i && issue_is_load_i && !bubble_s &&
                   (issue_dst_i == AW'(r));
    assign dec_s = wb_en_i && wb_is_load_i && (wb_addr_i == AW'(r)) && nz_s[r];
    sb_counter #(
      .MAX_OUT(MAX_OUT),
      .CW     (CW)
    ) u_cnt (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .clr_i  (flush_i),
      .en_i   (!stall_i),
      .inc_i  (inc_s),
      .dec_i  (dec_s),
      .cnt_o  (cnt_s[r]),
      .nz_o   (nz_s[r])
    );
  end

  // Storage write; register 0 is never written so it stays zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_fire_s) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Read ports with write-back bypass, forced to zero while reset is held.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!rst_n || (rd_addr_i[k*AW +: AW] == ADDR_R0)) begin
        rd_data_o[k*XLEN +: XLEN] = '0;
      end else if (wb_fire_s && (wb_addr_i == rd_addr_i[k*AW +: AW])) begin
        rd_data_o[k*XLEN +: XLEN] = wb_data_i;
      end else begin
        rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
      end
    end
  end

  // Load-use hazard: a source with loads in flight stalls, unless exactly one
  // is left and it is retiring right now (the bypass delivers its data).
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_en_i[k] && (rd_addr_i[k*AW +: AW] != ADDR_R0) &&
          nz_s[rd_addr_i[k*AW +: AW]] &&
          !((cnt_s[rd_addr_i[k*AW +: AW]] == CW'(1)) && wb_load_fire_s &&
            (wb_addr_i == rd_addr_i[k*AW +: AW]))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // A load to a register already at the outstanding limit must wait.
  assign full_s   = issue_en_i && issue_is_load_i &&
                    (cnt_s[issue_dst_i] == CW'(MAX_OUT));
  assign bubble_s = rst_n && !flush_i && (hazard_s || full_s);

  assign insert_bubble_o = bubble_s;
  assign busy_o          = nz_s;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the ID-stage register file and load-use bubble logic.
- Provides NRD combinational read ports with write-back bypass and one write-back port.
- Keeps a per-register scoreboard of outstanding loads (multi-cycle, multiple in flight), so the pipeline can have a variable-latency memory stage.
- Sits in ID: reads feed the ID/EX latch; bubble request goes to the hazard/IF-hold logic.

Parameters:
- XLEN, 32, register data width
- NREGS, 32, number of architectural registers; register 0 hard-wired to zero
- NRD, 2, number of read ports
- MAX_OUT, 3, maximum outstanding loads per destination register (counter saturation point)
- AW, $clog2(NREGS), register address width (derived)

Ports:
- sys_clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  pipeline stalled; suppresses register writes and all scoreboard updates
- flush_i  in  1  squash in-flight loads; clears the scoreboard
- rd_en_i  in  NRD  per-port read valid; port k qualifies hazard checking
- rd_addr_i  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  packed read data
- wb_en_i  in  1  write-back valid
- wb_addr_i  in  AW  write-back destination
- wb_data_i  in  XLEN  write-back data
- wb_is_load_i  in  1  write-back retires a load (decrements scoreboard)
- issue_en_i  in  1  instruction leaving ID this cycle
- issue_dst_i  in  AW  destination of issuing instruction
- issue_is_load_i  in  1  issuing instruction is a load
- insert_bubble_o  out  1  hold IF/ID, inject NOP into ID/EX
- busy_o  out  NREGS  per-register "count != 0" flags, for debug/forwarding

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers and counters are 0.
  - rd_data_o = 0, insert_bubble_o = 0, busy_o = 0 while reset is held.
  - Reset mid-operation discards every pending load.
- Write:
  - Occurs at the rising edge when wb_en_i && !stall_i && wb_addr_i != 0.
  - Writes to register 0 are dropped; register 0 reads as 0 always.
- Read:
  - Combinational.
  - Bypass: if wb_en_i && !stall_i && wb_addr_i == rd_addr && rd_addr != 0, then rd_data_o = wb_data_i; otherwise the stored value.
- Scoreboard:
  - Each register r ≥ 1 has a counter cnt[r] of width $clog2(MAX_OUT+1).
  - inc = issue_en_i && issue_is_load_i && !insert_bubble_o && issue_dst_i == r.
  - dec = wb_en_i && wb_is_load_i && wb_addr_i == r && cnt[r] != 0.
  - No update while stall_i; register 0 never counted.
  - inc && dec same cycle: cnt unchanged.
  - dec with cnt == 0 (stale load after flush): no underflow; the data write still happens.
  - flush_i: all cnt ← 0 at the next edge; it takes priority over inc/dec in the same cycle.
- Bubble (combinational):
  - insert_bubble_o = 1 when either condition holds:
    - (a) any port k with rd_en_i[k], addr != 0, and cnt[addr] != 0, except when cnt[addr] == 1 and the current write-back is a load to that addr (bypass covers it);
    - (b) issue_en_i && issue_is_load_i && cnt[issue_dst_i] == MAX_OUT.
  - While insert_bubble_o = 1, the issuing load is not counted.
  - insert_bubble_o is forced 0 during flush_i.
- Latency:
  - Read is 0 cycles.
  - Scoreboard state becomes visible the cycle after the edge.
  - A dependent instruction stalls from the cycle after the load issues until the load's write-back cycle, inclusive of bypass release.

Decomposition:
- Package rf_pkg: AW/counter-width helper functions; a named constant for register 0 (REG_ZERO).
- One sub-module, sb_counter: a single saturating up/down counter with clear. It is instantiated NREGS-1 times via generate and exposes cnt and a nonzero flag.

Test Plan:
- Reset:
  - Drive writes of 0xDEADBEEF to r5, then pulse rst_n low asynchronously mid-cycle.
  - Required: rd_data_o for r5 reads 0 immediately; busy_o = 0.
- Bypass:
  - wb r7 = 0x12345678 and read r7 on port 1 in the same cycle.
  - Required: port 1 = 0x12345678 that cycle; next cycle the stored value is the same. A write of 0xFFFFFFFF to r0 reads back 0.
- Load-use:
  - Issue load to r3; next cycle read r3 with rd_en_i.
  - Required: insert_bubble_o = 1 for each cycle until a wb of a load to r3, then 0 in the wb cycle with data bypassed.
- Multiple outstanding:
  - Issue 3 loads to r9 (MAX_OUT = 3), then a 4th.
  - Required: busy_o[9] = 1 and bubble on the 4th issue; after 3 load write-backs, busy_o[9] = 0.
- Simultaneous events:
  - Issue load to r4 while a load wb to r4 occurs (cnt = 1).
  - Required: cnt stays 1. stall_i high during the same event: no write, cnt unchanged.
- Flush:
  - With cnt[2] = 2, assert flush_i.
  - Required: busy_o[2] = 0 next cycle. A later stale load wb to r2 writes data with no underflow (busy_o[2] stays 0).
